// File: rtl/spi_xfer_ctrl.sv
// SPI mode-0 transfer sequencer. It pops a word from the TX FIFO, shifts it out MSB first
// while capturing MISO, pushes the received word to the RX FIFO, and keeps CS low for bursts.
module spi_xfer_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  enable_i,
  input  logic [DIV_WIDTH-1:0]  clk_div_i,
  input  logic                  tx_empty_i,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  output logic                  tx_rd_o,
  input  logic                  rx_full_i,
  output logic                  rx_wr_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  sclk_o,
  output logic                  mosi_o,
  input  logic                  miso_i,
  output logic                  cs_n_o,
  output logic                  busy_o
);

  // state | meaning
  // IDLE  | CS high, waiting for enable, TX data and RX space
  // LOAD  | pop TX head into shift register, drop CS
  // SHIFT | clock out DATA_WIDTH bits, sample MISO on SCLK rise
  // PUSH  | write received word to RX, chain next word if possible
  // HOLD  | keep CS low one half period before releasing it
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_PUSH,
    ST_HOLD
  } state_t;

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_shreg;
  logic [CNT_W-1:0]      r_bitcnt;
  logic [DIV_WIDTH-1:0]  r_div_cnt;
  logic [DIV_WIDTH-1:0]  r_div_lat;
  logic                  r_sclk;
  logic                  r_sample;
  logic                  r_cs_n;
  logic                  r_tx_rd;
  logic                  r_rx_wr;
  logic [DATA_WIDTH-1:0] r_rx_data;

  logic                  w_start;
  logic                  w_div_done;
  logic                  w_last_bit;
  logic [DATA_WIDTH-1:0] w_shreg_next;

  assign w_start      = enable_i & ~tx_empty_i & ~rx_full_i;
  assign w_div_done   = (r_div_cnt == '0);
  assign w_last_bit   = (r_bitcnt == CNT_W'(1));
  assign w_shreg_next = {r_shreg[DATA_WIDTH-2:0], r_sample};

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state   <= ST_IDLE;
      r_shreg   <= '0;
      r_bitcnt  <= '0;
      r_div_cnt <= '0;
      r_div_lat <= '0;
      r_sclk    <= 1'b0;
      r_sample  <= 1'b0;
      r_cs_n    <= 1'b1;
      r_tx_rd   <= 1'b0;
      r_rx_wr   <= 1'b0;
      r_rx_data <= '0;
    end else begin
      r_tx_rd <= 1'b0;
      r_rx_wr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cs_n <= 1'b1;
          r_sclk <= 1'b0;
          if (w_start) begin
            r_div_lat <= clk_div_i;
            r_tx_rd   <= 1'b1;
            r_state   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_shreg   <= tx_data_i;
          r_bitcnt  <= CNT_W'(DATA_WIDTH);
          r_cs_n    <= 1'b0;
          r_div_cnt <= r_div_lat;
          r_state   <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (w_div_done) begin
            r_div_cnt <= r_div_lat;
            r_sclk    <= ~r_sclk;
            if (!r_sclk) begin
              r_sample <= miso_i;
            end else begin
              r_shreg  <= w_shreg_next;
              r_bitcnt <= r_bitcnt - CNT_W'(1);
              // The push strobe and data are registered here so PUSH presents them directly.
              if (w_last_bit) begin
                r_rx_wr   <= 1'b1;
                r_rx_data <= w_shreg_next;
                r_state   <= ST_PUSH;
              end
            end
          end else begin
            r_div_cnt <= r_div_cnt - DIV_WIDTH'(1);
          end
        end
        ST_PUSH: begin
          if (w_start) begin
            r_tx_rd <= 1'b1;
            r_state <= ST_LOAD;
          end else begin
            r_div_cnt <= r_div_lat;
            r_state   <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (w_div_done) begin
            r_cs_n  <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_div_cnt <= r_div_cnt - DIV_WIDTH'(1);
          end
        end
        default: begin
          r_cs_n  <= 1'b1;
          r_sclk  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_rd_o   = r_tx_rd;
  assign rx_wr_o   = r_rx_wr;
  assign rx_data_o = r_rx_data;
  assign sclk_o    = r_sclk;
  assign mosi_o    = (r_state == ST_SHIFT) & r_shreg[DATA_WIDTH-1];
  assign cs_n_o    = r_cs_n;
  assign busy_o    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl (8-bit words). A TX FIFO model feeds the DUT, and each pop queues
// the expected RX word, which is compared when the DUT pushes.
module tb_spi_xfer_ctrl;
  localparam int DW  = 8;
  localparam int DVW = 8;

  logic           clk_i      = 1'b0;
  logic           reset_n_i  = 1'b1;
  logic           enable_i   = 1'b0;
  logic [DVW-1:0] clk_div_i  = 8'd1;
  logic           tx_empty_i = 1'b1;
  logic [DW-1:0]  tx_data_i  = '0;
  logic           tx_rd_o;
  logic           rx_full_i  = 1'b0;
  logic           rx_wr_o;
  logic [DW-1:0]  rx_data_o;
  logic           sclk_o;
  logic           mosi_o;
  logic           miso_i;
  logic           cs_n_o;
  logic           busy_o;

  logic miso_loop = 1'b1;
  logic miso_val  = 1'b0;
  assign miso_i = miso_loop ? mosi_o : miso_val;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int tx_rd_cnt = 0;
  int rx_wr_cnt = 0;
  logic [DW-1:0] txq[$];
  logic [DW-1:0] sb[$];
  logic [DW-1:0] exp_word;

  spi_xfer_ctrl #(.DATA_WIDTH(DW), .DIV_WIDTH(DVW)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .enable_i(enable_i), .clk_div_i(clk_div_i),
    .tx_empty_i(tx_empty_i), .tx_data_i(tx_data_i), .tx_rd_o(tx_rd_o),
    .rx_full_i(rx_full_i), .rx_wr_o(rx_wr_o), .rx_data_o(rx_data_o),
    .sclk_o(sclk_o), .mosi_o(mosi_o), .miso_i(miso_i), .cs_n_o(cs_n_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tx_refresh();
    tx_empty_i = (txq.size() == 0);
    tx_data_i  = (txq.size() != 0) ? txq[0] : '0;
  endtask

  task automatic tx_push(input logic [DW-1:0] w);
    txq.push_back(w);
    tx_refresh();
  endtask

  // Scoreboard monitor: a pop queues the expected word, and a push consumes it.
  always @(negedge clk_i) begin
    cyc++;
    if (tx_rd_o || rx_wr_o) begin
      n_checks++;
      if (tx_rd_o && rx_wr_o) begin
        n_errors++;
        $display("FAIL strobe_overlap: tx_rd_o=1 rx_wr_o=1 at cycle %0d, required not both", cyc);
      end
    end
    if (tx_rd_o) begin
      tx_rd_cnt++;
      n_checks++;
      if (tx_empty_i) begin
        n_errors++;
        $display("FAIL tx_underflow: pop while tx_empty_i=1 at cycle %0d", cyc);
      end
      sb.push_back(miso_loop ? tx_data_i : {DW{miso_val}});
    end
    if (rx_wr_o) begin
      rx_wr_cnt++;
      n_checks++;
      if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL rx_push_unexpected: rx_data_o=%h with nothing expected", rx_data_o);
      end else begin
        exp_word = sb.pop_front();
        if (rx_data_o !== exp_word) begin
          n_errors++;
          $display("FAIL rx_data: got %h, required %h", rx_data_o, exp_word);
        end
      end
    end
  end

  // Retire the TX head after the edge that ends the LOAD cycle.
  always @(negedge clk_i) begin
    if (tx_rd_o) begin
      @(posedge clk_i);
      #1;
      if (txq.size() != 0) void'(txq.pop_front());
      tx_refresh();
    end
  end

  task automatic step();
    @(negedge clk_i);
    #1;
  endtask

  function automatic logic cond_met(input int which);
    case (which)
      0:       return tx_rd_o === 1'b1;
      1:       return rx_wr_o === 1'b1;
      default: return busy_o === 1'b0;
    endcase
  endfunction

  task automatic wait_cond(input int which, input int budget, input string name);
    int n = 0;
    while (!cond_met(which) && n < budget) begin
      step();
      n++;
    end
    n_checks++;
    if (!cond_met(which)) begin
      n_errors++;
      $display("FAIL %s: timeout after %0d cycles, condition false, required true", name, budget);
    end
  endtask

  task automatic test_reset();
    logic [DW+5:0] got;
    step();
    step();
    got = {cs_n_o, sclk_o, mosi_o, tx_rd_o, rx_wr_o, busy_o, rx_data_o};
    n_checks++;
    if (got !== {6'b100000, {DW{1'b0}}}) begin
      n_errors++;
      $display("FAIL reset_outputs: got %b, required %b", got, {6'b100000, {DW{1'b0}}});
    end
    reset_n_i = 1'b1;
    repeat (3) step();
    got = {cs_n_o, sclk_o, mosi_o, tx_rd_o, rx_wr_o, busy_o, rx_data_o};
    n_checks++;
    if (got !== {6'b100000, {DW{1'b0}}}) begin
      n_errors++;
      $display("FAIL idle_after_reset: got %b, required %b", got, {6'b100000, {DW{1'b0}}});
    end
  endtask

  task automatic test_single_word();
    int rises = 0, first_rise = -1, last_rise = -1, bad_period = 0;
    int cs_bad = 0, wr_bad = 0, busy_bad = 0, rd_bad = 0;
    logic prev_sclk;
    logic exp_cs;
    clk_div_i = 8'd1;
    miso_loop = 1'b1;
    tx_push(8'hA5);
    enable_i = 1'b1;
    wait_cond(0, 20, "single_tx_rd");
    n_checks++;
    if (cs_n_o !== 1'b1) begin
      n_errors++;
      $display("FAIL single_cs_at_load: got %b, required 1", cs_n_o);
    end
    prev_sclk = sclk_o;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (sclk_o && !prev_sclk) begin
        rises++;
        if (first_rise < 0) first_rise = k;
        else if (k - last_rise != 4) bad_period++;
        last_rise = k;
      end
      prev_sclk = sclk_o;
      exp_cs = (k <= 35) ? 1'b0 : 1'b1;
      if (cs_n_o !== exp_cs) cs_bad++;
      if (rx_wr_o !== 1'(k == 33)) wr_bad++;
      if (tx_rd_o !== 1'b0) rd_bad++;
      if (k >= 36 && busy_o !== 1'b0) busy_bad++;
    end
    enable_i = 1'b0;
    n_checks++;
    if (rises != 8) begin n_errors++; $display("FAIL single_rises: got %0d, required 8", rises); end
    n_checks++;
    if (first_rise != 3) begin n_errors++; $display("FAIL single_first_rise: got %0d, required 3", first_rise); end
    n_checks++;
    if (bad_period != 0) begin n_errors++; $display("FAIL single_period: %0d bad intervals, required 0", bad_period); end
    n_checks++;
    if (cs_bad != 0) begin n_errors++; $display("FAIL single_cs_window: %0d bad cycles, required 0", cs_bad); end
    n_checks++;
    if (wr_bad != 0) begin n_errors++; $display("FAIL single_rx_wr_cycle33: %0d bad cycles, required 0", wr_bad); end
    n_checks++;
    if (rd_bad != 0) begin n_errors++; $display("FAIL single_extra_tx_rd: %0d bad cycles, required 0", rd_bad); end
    n_checks++;
    if (busy_bad != 0) begin n_errors++; $display("FAIL single_busy_after: %0d bad cycles, required 0", busy_bad); end
  endtask

  task automatic test_back_to_back();
    int nwr = 0, cs_bad = 0, wr1 = -1, rd2 = -1, n = 0;
    clk_div_i = 8'd1;
    miso_loop = 1'b0;
    miso_val  = 1'b1;
    tx_push(8'h3C);
    tx_push(8'hC3);
    enable_i = 1'b1;
    wait_cond(0, 20, "burst_tx_rd");
    while (nwr < 2 && n < 200) begin
      step();
      n++;
      if (cs_n_o !== 1'b0) cs_bad++;
      if (tx_rd_o && nwr == 1 && rd2 < 0) rd2 = cyc;
      if (rx_wr_o) begin
        nwr++;
        if (nwr == 1) wr1 = cyc;
      end
    end
    enable_i = 1'b0;
    n_checks++;
    if (nwr != 2) begin n_errors++; $display("FAIL burst_pushes: got %0d, required 2", nwr); end
    n_checks++;
    if (cs_bad != 0) begin n_errors++; $display("FAIL burst_cs_low: %0d high cycles, required 0", cs_bad); end
    n_checks++;
    if (rd2 != wr1 + 1) begin n_errors++; $display("FAIL burst_second_pop: cycle %0d, required %0d", rd2, wr1 + 1); end
    wait_cond(2, 20, "burst_idle");
    miso_loop = 1'b1;
  endtask

  task automatic test_rx_full_stall();
    int bad = 0;
    clk_div_i = 8'd1;
    rx_full_i = 1'b1;
    tx_push(8'h66);
    enable_i = 1'b1;
    repeat (20) begin
      step();
      if (tx_rd_o !== 1'b0 || cs_n_o !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_errors++; $display("FAIL stall_no_start: %0d bad cycles, required 0", bad); end
    rx_full_i = 1'b0;
    step();
    n_checks++;
    if (tx_rd_o !== 1'b1) begin n_errors++; $display("FAIL stall_release_load: tx_rd_o=%b, required 1", tx_rd_o); end
    enable_i = 1'b0;
    step();
    wait_cond(2, 60, "stall_idle");
  endtask

  task automatic test_disable_mid_word();
    int rd_before;
    clk_div_i = 8'd1;
    miso_loop = 1'b1;
    tx_push(8'h81);
    tx_push(8'h55);
    enable_i = 1'b1;
    wait_cond(0, 20, "disable_tx_rd");
    rd_before = tx_rd_cnt;
    repeat (13) step();
    enable_i = 1'b0;
    wait_cond(1, 40, "disable_push");
    step();
    n_checks++;
    if (cs_n_o !== 1'b0) begin n_errors++; $display("FAIL disable_hold1_cs: got %b, required 0", cs_n_o); end
    step();
    n_checks++;
    if (cs_n_o !== 1'b0) begin n_errors++; $display("FAIL disable_hold2_cs: got %b, required 0", cs_n_o); end
    step();
    n_checks++;
    if (cs_n_o !== 1'b1 || busy_o !== 1'b0) begin
      n_errors++;
      $display("FAIL disable_release: cs_n_o=%b busy_o=%b, required 1 0", cs_n_o, busy_o);
    end
    repeat (10) step();
    n_checks++;
    if (tx_rd_cnt != rd_before || txq.size() != 1) begin
      n_errors++;
      $display("FAIL disable_no_second_pop: pops %0d queue %0d, required %0d and 1", tx_rd_cnt, txq.size(), rd_before);
    end
    txq.delete();
    tx_refresh();
  endtask

  task automatic test_reset_mid_shift();
    int wr_before;
    logic [5:0] got;
    clk_div_i = 8'd1;
    miso_loop = 1'b1;
    tx_push(8'hA5);
    enable_i = 1'b1;
    wait_cond(0, 20, "rst_tx_rd");
    repeat (21) step();
    wr_before = rx_wr_cnt;
    #2;
    reset_n_i = 1'b0;
    #1;
    got = {cs_n_o, sclk_o, busy_o, rx_wr_o, tx_rd_o, mosi_o};
    n_checks++;
    if (got !== 6'b100000) begin n_errors++; $display("FAIL rst_async_outputs: got %b, required 100000", got); end
    sb.delete();
    repeat (3) step();
    reset_n_i = 1'b1;
    step();
    n_checks++;
    if (rx_wr_cnt != wr_before) begin n_errors++; $display("FAIL rst_no_push: pushes %0d, required %0d", rx_wr_cnt, wr_before); end
    tx_push(8'h3C);
    wait_cond(1, 60, "rst_next_push");
    enable_i = 1'b0;
    step();
    n_checks++;
    if (rx_wr_cnt != wr_before + 1) begin n_errors++; $display("FAIL rst_next_word: pushes %0d, required %0d", rx_wr_cnt, wr_before + 1); end
    wait_cond(2, 20, "rst_idle");
  endtask

  task automatic test_divider();
    int cfg_div[4]    = '{0, 255, 1, 3};
    int cfg_words[4]  = '{1, 1, 2, 1};
    int cfg_change[4] = '{-1, -1, 3, -1};
    int cfg_period[4] = '{2, 512, 4, 8};
    miso_loop = 1'b1;
    for (int c = 0; c < 4; c++) begin
      int rises = 0, last_rise = -1, bad = 0, nwr = 0, n = 0;
      logic prev_sclk;
      clk_div_i = DVW'(cfg_div[c]);
      tx_push(8'h5A);
      if (cfg_words[c] > 1) tx_push(8'hA5);
      enable_i = 1'b1;
      wait_cond(0, 20, "div_tx_rd");
      if (cfg_change[c] >= 0) clk_div_i = DVW'(cfg_change[c]);
      prev_sclk = sclk_o;
      while (nwr < cfg_words[c] && n < 6000) begin
        step();
        n++;
        if (sclk_o && !prev_sclk) begin
          rises++;
          if (last_rise >= 0 && cyc - last_rise != cfg_period[c]) bad++;
          last_rise = cyc;
        end
        prev_sclk = sclk_o;
        if (rx_wr_o) begin
          nwr++;
          last_rise = -1;
        end
      end
      enable_i = 1'b0;
      n_checks++;
      if (rises != 8 * cfg_words[c] || bad != 0) begin
        n_errors++;
        $display("FAIL div_period cfg%0d: rises %0d bad %0d, required %0d rises of period %0d",
                 c, rises, bad, 8 * cfg_words[c], cfg_period[c]);
      end
      wait_cond(2, 600, "div_idle");
    end
  endtask

  initial begin
    tx_refresh();
    #1 reset_n_i = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_rx_full_stall();
    test_disable_mid_word();
    test_reset_mid_shift();
    test_divider();
    repeat (3) step();
    n_checks++;
    if (sb.size() != 0 || txq.size() != 0) begin
      n_errors++;
      $display("FAIL end_queues: scoreboard %0d tx %0d, required 0 0", sb.size(), txq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
